ntt_stream_gearbox: RTL and testbench

Parametrised successor to the fixed one-coefficient-per-cycle IO wrapper around the NTT core. It deserialises a valid/ready coefficient stream of LANES coefficients per beat into full INPUT_PER_CYCLE-wide core words, tagged with polynomial start. It reserialises core output words into a backpressured LANES-wide stream with first/last framing. It sits between the system stream fabric and NTT_Top, and flags misalignment and output overflow.

---
 rtl/ntt_io_pkg.sv | 26 ++
 rtl/ntt_word_fifo2.sv | 67 ++++++
 rtl/ntt_stream_gearbox.sv | 207 ++++++++++++++++++++
 tb/tb_ntt_stream_gearbox.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_io_pkg.sv
// Shared types, defaults and sizing helpers for the NTT stream gearbox.
package ntt_io_pkg;

  localparam int unsigned COEF_W  = 28;
  localparam int unsigned DEF_P   = 128;
  localparam int unsigned DEF_L   = 4;
  localparam int unsigned DEF_WPP = 32;
  localparam int unsigned DEF_SF  = 11;

  typedef logic [COEF_W-1:0] coef_t;

  // Counter width that never collapses to zero bits for single-value ranges.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned BEATS   = DEF_P / DEF_L;
  localparam int unsigned BEAT_CW = cnt_w(BEATS);
  localparam int unsigned WORD_CW = cnt_w(DEF_WPP);

  typedef struct packed {
    logic [DEF_P-1:0][COEF_W-1:0] word;
    logic                         start;
  } out_entry_t;

endpackage

// File: rtl/ntt_word_fifo2.sv
// Two-entry FIFO with the head held in a fixed slot; pushes into a full FIFO
// without a simultaneous pop are dropped and flagged.
module ntt_word_fifo2
  import ntt_io_pkg::*;
#(
  parameter int unsigned DW = $bits(out_entry_t)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_data_o,
  output logic          head_valid_o,
  output logic          full_o,
  output logic          drop_c_o
);

  logic [DW-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic          v0_q, v0_d, v1_q, v1_d;
  logic          do_pop, do_push;

  assign do_pop   = pop_i & v0_q;
  assign do_push  = push_i & (~v1_q | do_pop);
  assign drop_c_o = push_i & v1_q & ~do_pop;

  // Pop shifts slot1 forward first, then a push lands in the first free slot.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    if (do_pop) begin
      slot0_d = slot1_q;
      v0_d    = v1_q;
      v1_d    = 1'b0;
    end
    if (do_push) begin
      if (!v0_d) begin
        slot0_d = push_data_i;
        v0_d    = 1'b1;
      end else begin
        slot1_d = push_data_i;
        v1_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot0_q <= '0;
      slot1_q <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
    end
  end

  assign head_data_o  = slot0_q;
  assign head_valid_o = v0_q;
  assign full_o       = v1_q;

endmodule

// File: rtl/ntt_stream_gearbox.sv
// Gearbox between a LANES-wide coefficient stream and full-width NTT core words,
// in both directions, with alignment and overflow error flags.
module ntt_stream_gearbox
  import ntt_io_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_PER_INPUT = COEF_W,
  parameter int unsigned INPUT_PER_CYCLE      = DEF_P,
  parameter int unsigned LANES                = DEF_L,
  parameter int unsigned WORDS_PER_POLY       = DEF_WPP,
  parameter int unsigned START_FANOUT         = DEF_SF
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  s_valid_i,
  output logic                                  s_ready_o,
  input  logic                                  s_first_i,
  input  logic [LANES*DATA_WIDTH_PER_INPUT-1:0] s_data_i,
  output logic [DATA_WIDTH_PER_INPUT-1:0]       core_in_data_o [INPUT_PER_CYCLE],
  output logic                                  core_in_valid_o,
  output logic [START_FANOUT-1:0]               core_in_start_o,
  input  logic [DATA_WIDTH_PER_INPUT-1:0]       core_out_data_i [INPUT_PER_CYCLE],
  input  logic                                  core_out_valid_i,
  input  logic [START_FANOUT-1:0]               core_out_start_i,
  output logic                                  m_valid_o,
  input  logic                                  m_ready_i,
  output logic [LANES*DATA_WIDTH_PER_INPUT-1:0] m_data_o,
  output logic                                  m_first_o,
  output logic                                  m_last_o,
  output logic                                  err_align_o,
  output logic                                  err_ovf_o
);

  localparam int unsigned W   = DATA_WIDTH_PER_INPUT;
  localparam int unsigned P   = INPUT_PER_CYCLE;
  localparam int unsigned L   = LANES;
  localparam int unsigned NB  = P / L;
  localparam int unsigned WPP = WORDS_PER_POLY;
  localparam int unsigned SF  = START_FANOUT;
  localparam int unsigned BW  = cnt_w(NB);
  localparam int unsigned WW  = cnt_w(WPP);

  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(WPP - 1);

  if ((P % L) != 0) begin : g_bad_lanes
    $error("INPUT_PER_CYCLE must be a multiple of LANES");
  end
  if ((WPP & (WPP - 1)) != 0) begin : g_bad_wpp
    $error("WORDS_PER_POLY must be a power of two");
  end

  typedef struct packed {
    logic [P-1:0][W-1:0] word;
    logic                start;
  } entry_t;

  // ---------------- input deserialiser ----------------
  logic [BW-1:0]   ib_q, ib_d, beat;
  logic [WW-1:0]   iw_q, iw_d, word;
  logic [W-1:0]    acc_q [P];
  logic [W-1:0]    acc_d [P];
  logic [W-1:0]    cin_data_q [P];
  logic [W-1:0]    cin_data_d [P];
  logic            cin_valid_q, cin_valid_d;
  logic [SF-1:0]   cin_start_q, cin_start_d;
  logic            err_align_q, err_align_d;
  logic            accept;

  assign s_ready_o = ~rst_i;
  assign accept    = s_valid_i & ~rst_i;

  // A misplaced s_first restarts the polynomial at beat 0 of word 0.
  always_comb begin
    ib_d        = ib_q;
    iw_d        = iw_q;
    acc_d       = acc_q;
    cin_data_d  = cin_data_q;
    cin_valid_d = 1'b0;
    cin_start_d = '0;
    err_align_d = err_align_q;
    beat        = ib_q;
    word        = iw_q;
    if (accept) begin
      if (s_first_i && ((ib_q != '0) || (iw_q != '0))) begin
        err_align_d = 1'b1;
        beat        = '0;
        word        = '0;
      end
      for (int b = 0; b < NB; b++) begin
        if (beat == BW'(b)) begin
          for (int k = 0; k < L; k++) begin
            acc_d[b*L + k] = s_data_i[k*W +: W];
          end
        end
      end
      if (beat == LAST_BEAT) begin
        cin_data_d  = acc_d;
        cin_valid_d = 1'b1;
        cin_start_d = {SF{word == '0}};
        ib_d        = '0;
        iw_d        = (word == LAST_WORD) ? '0 : word + WW'(1);
      end else begin
        ib_d = beat + BW'(1);
        iw_d = word;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ib_q        <= '0;
      iw_q        <= '0;
      cin_valid_q <= 1'b0;
      cin_start_q <= '0;
      err_align_q <= 1'b0;
      for (int i = 0; i < P; i++) begin
        acc_q[i]      <= '0;
        cin_data_q[i] <= '0;
      end
    end else begin
      ib_q        <= ib_d;
      iw_q        <= iw_d;
      cin_valid_q <= cin_valid_d;
      cin_start_q <= cin_start_d;
      err_align_q <= err_align_d;
      acc_q       <= acc_d;
      cin_data_q  <= cin_data_d;
    end
  end

  assign core_in_data_o  = cin_data_q;
  assign core_in_valid_o = cin_valid_q;
  assign core_in_start_o = cin_start_q;
  assign err_align_o     = err_align_q;

  // ---------------- output serialiser ----------------
  entry_t        push_ent, head_ent;
  logic          head_valid, pop, drop;
  logic          unused_fifo_full, unused_start_bits;
  logic [BW-1:0] ob_q, ob_d;
  logic [WW-1:0] ow_q, ow_d, ow_eff;
  logic          err_ovf_q, err_ovf_d;

  assign unused_start_bits = ^core_out_start_i;

  always_comb begin
    push_ent.start = core_out_start_i[0];
    for (int i = 0; i < P; i++) begin
      push_ent.word[i] = core_out_data_i[i];
    end
  end

  ntt_word_fifo2 #(.DW($bits(entry_t))) u_out_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (core_out_valid_i),
    .push_data_i  (push_ent),
    .pop_i        (pop),
    .head_data_o  (head_ent),
    .head_valid_o (head_valid),
    .full_o       (unused_fifo_full),
    .drop_c_o     (drop)
  );

  // A start-tagged head word realigns the output word counter to 0.
  always_comb begin
    ow_eff    = head_ent.start ? '0 : ow_q;
    pop       = head_valid & m_ready_i & (ob_q == LAST_BEAT);
    ob_d      = ob_q;
    ow_d      = ow_q;
    err_ovf_d = err_ovf_q | drop;
    m_data_o  = '0;
    if (head_valid && m_ready_i) begin
      if (ob_q == LAST_BEAT) begin
        ob_d = '0;
        ow_d = (ow_eff == LAST_WORD) ? '0 : ow_eff + WW'(1);
      end else begin
        ob_d = ob_q + BW'(1);
      end
    end
    for (int b = 0; b < NB; b++) begin
      if (ob_q == BW'(b)) begin
        for (int k = 0; k < L; k++) begin
          m_data_o[k*W +: W] = head_ent.word[b*L + k];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ob_q      <= '0;
      ow_q      <= '0;
      err_ovf_q <= 1'b0;
    end else begin
      ob_q      <= ob_d;
      ow_q      <= ow_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign m_valid_o = head_valid;
  assign m_first_o = head_valid & head_ent.start & (ob_q == '0);
  assign m_last_o  = head_valid & (ow_eff == LAST_WORD) & (ob_q == LAST_BEAT);
  assign err_ovf_o = err_ovf_q;

endmodule

// File: tb/tb_ntt_stream_gearbox.sv
// Directed bench for ntt_stream_gearbox with P=8, L=2, two words per polynomial.
module tb_ntt_stream_gearbox;

  localparam int unsigned W  = 28;
  localparam int unsigned P  = 8;
  localparam int unsigned L  = 2;
  localparam int unsigned SF = 11;

  logic            clk, rst;
  logic            s_valid, s_ready, s_first;
  logic [L*W-1:0]  s_data;
  logic [W-1:0]    core_in_data [P];
  logic            core_in_valid;
  logic [SF-1:0]   core_in_start;
  logic [W-1:0]    core_out_data [P];
  logic            core_out_valid;
  logic [SF-1:0]   core_out_start;
  logic            m_valid, m_ready, m_first, m_last;
  logic [L*W-1:0]  m_data;
  logic            err_align, err_ovf;

  int n_pass  = 0;
  int n_total = 0;
  logic [L*W+1:0] got_q [$];

  ntt_stream_gearbox #(
    .DATA_WIDTH_PER_INPUT(W), .INPUT_PER_CYCLE(P), .LANES(L),
    .WORDS_PER_POLY(2), .START_FANOUT(SF)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_first_i(s_first), .s_data_i(s_data),
    .core_in_data_o(core_in_data), .core_in_valid_o(core_in_valid),
    .core_in_start_o(core_in_start),
    .core_out_data_i(core_out_data), .core_out_valid_i(core_out_valid),
    .core_out_start_i(core_out_start),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
    .m_first_o(m_first), .m_last_o(m_last),
    .err_align_o(err_align), .err_ovf_o(err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output beat that completes a handshake at the next rising edge.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) got_q.push_back({m_first, m_last, m_data});
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [255:0] word_of(input int base);
    logic [255:0] r = '0;
    for (int i = 0; i < P; i++) r[i*W +: W] = W'(base + i);
    return r;
  endfunction

  function automatic logic [255:0] cin_word();
    logic [255:0] r = '0;
    for (int i = 0; i < P; i++) r[i*W +: W] = core_in_data[i];
    return r;
  endfunction

  task automatic beat(input logic first, input int a);
    s_valid = 1'b1;
    s_first = first;
    s_data  = {W'(a + 1), W'(a)};
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_first = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Two words of 8 coefficients; base..base+15 in stream order.
  task automatic send_poly(input int base, input bit gaps, input string tag);
    for (int w = 0; w < 2; w++) begin
      for (int b = 0; b < 4; b++) begin
        beat(w == 0 && b == 0, base + w*8 + b*2);
        if (b == 3) begin
          check({tag, "_valid"}, core_in_valid, 1);
          check({tag, "_data"}, cin_word(), word_of(base + w*8));
          check({tag, "_start"}, core_in_start, (w == 0) ? 11'h7FF : 11'h000);
        end else begin
          check({tag, "_novalid"}, core_in_valid, 0);
        end
        if (gaps) idle(1);
      end
    end
  endtask

  task automatic core_push(input logic st, input int base);
    for (int i = 0; i < P; i++) core_out_data[i] = W'(base + i);
    core_out_start = st ? '1 : '0;
    core_out_valid = 1'b1;
    @(posedge clk); #1;
    core_out_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n, input string tag);
    int cyc = 0;
    while (got_q.size() < n && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check({tag, "_count"}, got_q.size(), n);
  endtask

  // Expected serialisation of words 1..8 (start) and 9..16.
  task automatic check_poly_out(input string tag);
    logic [L*W+1:0] got, exp;
    for (int k = 0; k < 8; k++) begin
      exp = {k == 0, k == 7, W'(2*k + 2), W'(2*k + 1)};
      got = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      check({tag, "_beat"}, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_first = 1'b0; s_data = '0;
    core_out_valid = 1'b0; core_out_start = '0; m_ready = 1'b0;
    for (int i = 0; i < P; i++) core_out_data[i] = '0;
    idle(2);

    check("rst_s_ready", s_ready, 0);
    check("rst_cin_valid", core_in_valid, 0);
    check("rst_cin_start", core_in_start, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_errs", {err_align, err_ovf}, 0);
    rst = 1'b0;
    #1;
    check("s_ready_up", s_ready, 1);

    // 1: back-to-back beats
    send_poly(1, 1'b0, "t1");
    idle(1);
    check("t1_pulse_end", core_in_valid, 0);
    check("t1_hold", cin_word(), word_of(9));

    // 2: one idle cycle between beats
    send_poly(1, 1'b1, "t2");
    check("t2_no_err", err_align, 0);

    // 3: s_first mid-word
    beat(1'b1, 200);
    check("t3_first_ok", err_align, 0);
    beat(1'b0, 202);
    beat(1'b1, 100);
    check("t3_err_align", err_align, 1);
    beat(1'b0, 102);
    beat(1'b0, 104);
    beat(1'b0, 106);
    check("t3_valid", core_in_valid, 1);
    check("t3_data", cin_word(), word_of(100));
    check("t3_start", core_in_start, 11'h7FF);
    for (int b = 0; b < 4; b++) beat(1'b0, 108 + 2*b);
    check("t3_w1_data", cin_word(), word_of(108));
    check("t3_w1_start", core_in_start, 0);
    check("t3_sticky", err_align, 1);

    // 4: serialise one polynomial with m_ready high
    m_ready = 1'b1;
    core_push(1'b1, 1);
    core_push(1'b0, 9);
    wait_beats(8, "t4");
    check_poly_out("t4");

    // 5: overflow while stalled
    m_ready = 1'b0;
    core_push(1'b1, 1);
    core_push(1'b0, 9);
    check("t5_no_ovf", err_ovf, 0);
    core_push(1'b1, 17);
    check("t5_ovf", err_ovf, 1);
    idle(3);
    check("t5_m_valid", m_valid, 1);
    check("t5_stall_data", m_data, {W'(2), W'(1)});
    check("t5_stall_first", m_first, 1);
    m_ready = 1'b1;
    wait_beats(8, "t5");
    check_poly_out("t5");
    idle(6);
    check("t5_no_extra", got_q.size(), 0);
    check("t5_empty", m_valid, 0);

    // 6: reset mid-word and mid-serialisation
    m_ready = 1'b0;
    core_push(1'b1, 1);
    beat(1'b1, 50);
    beat(1'b0, 52);
    rst = 1'b1;
    idle(1);
    check("t6_s_ready", s_ready, 0);
    check("t6_m", {m_valid, m_first, m_last}, 0);
    check("t6_m_data", m_data, 0);
    check("t6_cin", {core_in_valid, core_in_start}, 0);
    check("t6_cin_data", cin_word(), 0);
    check("t6_errs", {err_align, err_ovf}, 0);
    rst = 1'b0;
    got_q.delete();
    m_ready = 1'b1;
    #1;
    check("t6_ready_up", s_ready, 1);
    send_poly(1, 1'b0, "t6");
    check("t6_no_err", err_align, 0);
    idle(4);
    check("t6_no_out", got_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
